// File: rtl/gbt_link_sequencer_pkg.sv
// Shared types and constants for the GBT link reset sequencer.
package MCPkg;

  // Sequencer states; encodings 6 and 7 are unused and recover to RESET_PLL.
  typedef enum logic [2:0] {
    RESET_PLL  = 3'd0,
    WAIT_LOCK  = 3'd1,
    RESET_GBT  = 3'd2,
    WAIT_READY = 3'd3,
    LINK_UP    = 3'd4,
    HOLDOFF    = 3'd5
  } t_gbt_seq_state;

  // Saturation point of the retry counter.
  localparam logic [7:0] c_gbt_retry_max = 8'd255;

  // Clock and reset bundle shared by blocks of the 120 MHz domain.
  typedef struct packed {
    logic clk;
    logic reset;
  } t_clk_rs;

endpackage

// File: rtl/gbt_link_sequencer_ms_timer.sv
// Millisecond counter used by the link sequencer to time each state.
// Counts tick_i pulses, clears on clr_i (clear wins over a tick), and
// reports expiry as count >= limit. Saturates instead of wrapping.
module gbt_seq_ms_timer #(
  parameter int g_cnt_w = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               tick_i,
  input  logic [g_cnt_w-1:0] limit_i,
  output logic               expired_o
);

  logic [g_cnt_w-1:0] cnt_d;
  logic [g_cnt_w-1:0] cnt_q;

  // Next count: clear has priority, otherwise count ticks up to all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_i && !(&cnt_q)) begin
      cnt_d = cnt_q + g_cnt_w'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q >= limit_i);

endmodule

// File: rtl/gbt_link_sequencer.sv
// GBT optical link reset sequencer (120 MHz domain).
// Sequences PLL reset, GBT Tx/Rx reset and readiness checks with bounded
// retries, holds the link down while loss-of-signal persists, and keeps a
// saturating count of failed bring-up attempts. All outputs are registered
// from the next-state value so they change together with state_o.
module gbt_link_sequencer
  import MCPkg::*;
#(
  parameter int g_pll_rst_ms       = 2,
  parameter int g_lock_timeout_ms  = 100,
  parameter int g_gbt_rst_ms       = 1,
  parameter int g_ready_timeout_ms = 2400,
  parameter int g_holdoff_ms       = 10,
  parameter int g_cnt_w            = 12
) (
  input  t_clk_rs     ClkRs_ix,
  input  logic        tick_1ms_i,
  input  logic        los_i,
  input  logic        pll_locked_i,
  input  logic        tx_ready_i,
  input  logic        rx_ready_i,
  input  logic        clear_stats_i,
  output logic        pll_reset_o,
  output logic        gbt_tx_reset_o,
  output logic        gbt_rx_reset_o,
  output logic        link_up_o,
  output logic [2:0]  state_o,
  output logic [7:0]  retry_count_o
);

  localparam logic [g_cnt_w-1:0] c_lim_pll     = g_cnt_w'(g_pll_rst_ms);
  localparam logic [g_cnt_w-1:0] c_lim_lock    = g_cnt_w'(g_lock_timeout_ms);
  localparam logic [g_cnt_w-1:0] c_lim_gbt     = g_cnt_w'(g_gbt_rst_ms);
  localparam logic [g_cnt_w-1:0] c_lim_ready   = g_cnt_w'(g_ready_timeout_ms);
  localparam logic [g_cnt_w-1:0] c_lim_holdoff = g_cnt_w'(g_holdoff_ms);

  logic clk;
  logic rst;

  assign clk = ClkRs_ix.clk;
  assign rst = ClkRs_ix.reset;

  // Synchroniser stages, bit order {los, lock, tx_ready, rx_ready}.
  logic [3:0] meta_d, meta_q;
  logic [3:0] sync_d, sync_q;
  logic       los_s, lock_s, tx_rdy_s, rx_rdy_s;

  t_gbt_seq_state state_d, state_q;
  logic           entry_d, entry_q;
  logic [7:0]     retry_d, retry_q;
  logic           pll_reset_d, pll_reset_q;
  logic           gbt_reset_d, gbt_reset_q;
  logic           link_up_d, link_up_q;
  logic           retry_inc;
  logic           tmr_clr;
  logic           tmr_expired;
  logic [g_cnt_w-1:0] tmr_limit;

  // Two-stage capture of the asynchronous status inputs.
  always_comb begin
    meta_d = {los_i, pll_locked_i, tx_ready_i, rx_ready_i};
    sync_d = meta_q;
  end

  assign {los_s, lock_s, tx_rdy_s, rx_rdy_s} = sync_q;

  // Timeout limit for the state currently being timed.
  always_comb begin
    case (state_q)
      RESET_PLL:  tmr_limit = c_lim_pll;
      WAIT_LOCK:  tmr_limit = c_lim_lock;
      RESET_GBT:  tmr_limit = c_lim_gbt;
      WAIT_READY: tmr_limit = c_lim_ready;
      HOLDOFF:    tmr_limit = c_lim_holdoff;
      default:    tmr_limit = '0;
    endcase
  end

  // Next state: LOS first, then lock loss, then the state-local rules.
  always_comb begin
    state_d   = state_q;
    retry_inc = 1'b0;
    if (state_q > HOLDOFF) begin
      state_d = RESET_PLL;
    end else if (los_s) begin
      state_d = HOLDOFF;
    end else if (!lock_s &&
                 (state_q == RESET_GBT || state_q == WAIT_READY || state_q == LINK_UP)) begin
      state_d   = RESET_PLL;
      retry_inc = 1'b1;
    end else begin
      case (state_q)
        RESET_PLL: begin
          if (tmr_expired) state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = RESET_GBT;
          end else if (tmr_expired) begin
            state_d   = RESET_PLL;
            retry_inc = 1'b1;
          end
        end
        RESET_GBT: begin
          if (tmr_expired) state_d = WAIT_READY;
        end
        WAIT_READY: begin
          if (tx_rdy_s && rx_rdy_s) begin
            state_d = LINK_UP;
          end else if (tmr_expired) begin
            state_d   = RESET_PLL;
            retry_inc = 1'b1;
          end
        end
        LINK_UP: begin
          if (!(tx_rdy_s && rx_rdy_s)) begin
            state_d   = RESET_GBT;
            retry_inc = 1'b1;
          end
        end
        HOLDOFF: begin
          if (tmr_expired) state_d = RESET_PLL;
        end
        default: state_d = RESET_PLL;
      endcase
    end
  end

  // The counter is zero on entry and stays zero through the entry cycle, so a
  // tick there is dropped; LOS in HOLDOFF also pins it at zero.
  always_comb begin
    entry_d = (state_d != state_q);
    tmr_clr = entry_d || entry_q || (state_q == HOLDOFF && los_s);
  end

  // Retry counter: clear beats a coincident increment; saturates at the max.
  always_comb begin
    retry_d = retry_q;
    if (clear_stats_i) begin
      retry_d = '0;
    end else if (retry_inc && (retry_q != c_gbt_retry_max)) begin
      retry_d = retry_q + 8'd1;
    end
  end

  // Output decode from the next state so outputs switch with state_o.
  always_comb begin
    pll_reset_d = (state_d == RESET_PLL) || (state_d == HOLDOFF);
    gbt_reset_d = (state_d == RESET_PLL) || (state_d == WAIT_LOCK) ||
                  (state_d == RESET_GBT) || (state_d == HOLDOFF);
    link_up_d   = (state_d == LINK_UP);
  end

  // All control and output registers, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q      <= '0;
      sync_q      <= '0;
      state_q     <= RESET_PLL;
      entry_q     <= 1'b1;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      gbt_reset_q <= 1'b1;
      link_up_q   <= 1'b0;
    end else begin
      meta_q      <= meta_d;
      sync_q      <= sync_d;
      state_q     <= state_d;
      entry_q     <= entry_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      gbt_reset_q <= gbt_reset_d;
      link_up_q   <= link_up_d;
    end
  end

  gbt_seq_ms_timer #(
    .g_cnt_w (g_cnt_w)
  ) u_ms_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (tmr_clr),
    .tick_i    (tick_1ms_i),
    .limit_i   (tmr_limit),
    .expired_o (tmr_expired)
  );

  assign pll_reset_o    = pll_reset_q;
  assign gbt_tx_reset_o = gbt_reset_q;
  assign gbt_rx_reset_o = gbt_reset_q;
  assign link_up_o      = link_up_q;
  assign state_o        = state_q;
  assign retry_count_o  = retry_q;

endmodule

// File: tb/tb_gbt_link_sequencer.sv
// Self-checking bench for gbt_link_sequencer: a reference model of the
// sequencing rules is compared against the DUT on every falling edge, and
// directed scenarios pin key values with hand-computed constants.
module tb_gbt_link_sequencer;
  import MCPkg::*;

  logic       clk;
  logic       rst;
  logic       tick_1ms;
  logic       los;
  logic       lock;
  logic       tx_rdy;
  logic       rx_rdy;
  logic       clear_stats;
  logic       pll_reset;
  logic       gbt_tx_reset;
  logic       gbt_rx_reset;
  logic       link_up;
  logic [2:0] state;
  logic [7:0] retry_count;
  t_clk_rs    clk_rs;

  assign clk_rs.clk   = clk;
  assign clk_rs.reset = rst;

  gbt_link_sequencer #(
    .g_pll_rst_ms       (2),
    .g_lock_timeout_ms  (5),
    .g_gbt_rst_ms       (1),
    .g_ready_timeout_ms (8),
    .g_holdoff_ms       (3),
    .g_cnt_w            (12)
  ) dut (
    .ClkRs_ix       (clk_rs),
    .tick_1ms_i     (tick_1ms),
    .los_i          (los),
    .pll_locked_i   (lock),
    .tx_ready_i     (tx_rdy),
    .rx_ready_i     (rx_rdy),
    .clear_stats_i  (clear_stats),
    .pll_reset_o    (pll_reset),
    .gbt_tx_reset_o (gbt_tx_reset),
    .gbt_rx_reset_o (gbt_rx_reset),
    .link_up_o      (link_up),
    .state_o        (state),
    .retry_count_o  (retry_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 1 ms tick: one-cycle pulse every 10 clocks, changed on falling edges.
  initial begin
    tick_1ms = 1'b0;
    forever begin
      repeat (9) @(negedge clk);
      tick_1ms = 1'b1;
      @(negedge clk);
      tick_1ms = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // State lasts while "ms elapsed" = ticks seen since counting started is
  // below the state's limit; counting starts after the entry cycle.
  int        m_st;
  int        m_retry;
  int        m_ticks;
  int        m_base;
  bit        m_entry;
  bit  [1:0] h_los, h_lock, h_tx, h_rx;

  function automatic int lim(input int s);
    case (s)
      0: return 2;
      1: return 5;
      2: return 1;
      3: return 8;
      5: return 3;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin : ref_model
    int nxt;
    bit bump;
    bit rdy;
    int elapsed;
    if (rst) begin
      m_st    = 0;
      m_retry = 0;
      m_base  = m_ticks;
      m_entry = 1'b1;
      h_los   = '0;
      h_lock  = '0;
      h_tx    = '0;
      h_rx    = '0;
    end else begin
      elapsed = m_ticks - m_base;
      rdy     = h_tx[1] && h_rx[1];
      nxt     = m_st;
      bump    = 1'b0;
      if (m_st > 5) nxt = 0;
      else if (h_los[1]) nxt = 5;
      else if ((m_st >= 2 && m_st <= 4) && !h_lock[1]) begin
        nxt = 0; bump = 1'b1;
      end else if (m_st == 0 && elapsed >= lim(0)) nxt = 1;
      else if (m_st == 1 && h_lock[1]) nxt = 2;
      else if (m_st == 1 && elapsed >= lim(1)) begin
        nxt = 0; bump = 1'b1;
      end else if (m_st == 2 && elapsed >= lim(2)) nxt = 3;
      else if (m_st == 3 && rdy) nxt = 4;
      else if (m_st == 3 && elapsed >= lim(3)) begin
        nxt = 0; bump = 1'b1;
      end else if (m_st == 4 && !rdy) begin
        nxt = 2; bump = 1'b1;
      end else if (m_st == 5 && elapsed >= lim(5)) nxt = 0;

      if (clear_stats) m_retry = 0;
      else if (bump && m_retry < 255) m_retry = m_retry + 1;

      if (tick_1ms) m_ticks = m_ticks + 1;
      if (nxt != m_st) begin
        m_base  = m_ticks;
        m_entry = 1'b1;
      end else if (m_entry || (m_st == 5 && h_los[1])) begin
        m_base  = m_ticks;
        m_entry = 1'b0;
      end
      m_st   = nxt;
      h_los  = {h_los[0], los};
      h_lock = {h_lock[0], lock};
      h_tx   = {h_tx[0], tx_rdy};
      h_rx   = {h_rx[0], rx_rdy};
    end
  end

  function automatic bit bumps_next();
    return (m_st == 1) && !h_los[1] && !h_lock[1] && ((m_ticks - m_base) >= lim(1));
  endfunction

  // ---------------- checking ----------------
  int n_cmp;
  int n_err;
  int seq[$];
  int last_st;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Advance to the next falling edge and compare every output to the model.
  task automatic step();
    int e_pll, e_gbt, e_up;
    @(negedge clk);
    e_pll = (m_st == 0 || m_st == 5) ? 1 : 0;
    e_gbt = (m_st == 0 || m_st == 1 || m_st == 2 || m_st == 5) ? 1 : 0;
    e_up  = (m_st == 4) ? 1 : 0;
    n_cmp++;
    if (int'(state) != m_st || int'(pll_reset) != e_pll || int'(gbt_tx_reset) != e_gbt ||
        int'(gbt_rx_reset) != e_gbt || int'(link_up) != e_up || int'(retry_count) != m_retry) begin
      n_err++;
      $display("FAIL model t=%0t: got st=%0d pll=%0d tx=%0d rx=%0d up=%0d rc=%0d, expected st=%0d pll=%0d gbt=%0d up=%0d rc=%0d",
               $time, state, pll_reset, gbt_tx_reset, gbt_rx_reset, link_up, retry_count,
               m_st, e_pll, e_gbt, e_up, m_retry);
    end
    if (int'(state) != last_st) begin
      seq.push_back(int'(state));
      last_st = int'(state);
    end
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int n;
    n = 0;
    while (int'(state) != s && n < budget) begin
      step();
      n++;
    end
    chk(name, int'(state), s);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int  t0;
    int  exp_rc;
    bit  found;
    n_cmp       = 0;
    n_err       = 0;
    last_st     = 0;
    rst         = 1'b1;
    los         = 1'b0;
    lock        = 1'b0;
    tx_rdy      = 1'b0;
    rx_rdy      = 1'b0;
    clear_stats = 1'b0;

    repeat (3) step();
    chk("rst_state", int'(state), 0);
    chk("rst_pll", int'(pll_reset), 1);
    chk("rst_gbt_tx", int'(gbt_tx_reset), 1);
    chk("rst_gbt_rx", int'(gbt_rx_reset), 1);
    chk("rst_link_up", int'(link_up), 0);
    chk("rst_retry", int'(retry_count), 0);

    // Nominal bring-up.
    seq.delete();
    last_st = 0;
    rst = 1'b0;
    wait_state(1, 100, "nom_wait_lock");
    repeat (10) step();
    lock = 1'b1;
    wait_state(2, 20, "nom_reset_gbt");
    wait_state(3, 50, "nom_wait_ready");
    repeat (5) step();
    tx_rdy = 1'b1;
    rx_rdy = 1'b1;
    wait_state(4, 20, "nom_link_up");
    chk("nom_seq_len", seq.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("nom_seq%0d", i), (i < seq.size()) ? seq[i] : -1, i + 1);
    chk("nom_link_up_o", int'(link_up), 1);
    chk("nom_retry", int'(retry_count), 0);

    // Ready drop in LINK_UP.
    rx_rdy = 1'b0;
    step();
    step();
    chk("rdrop_2clk_state", int'(state), 4);
    step();
    chk("rdrop_3clk_state", int'(state), 2);
    chk("rdrop_retry", int'(retry_count), 1);
    rx_rdy = 1'b1;
    wait_state(4, 60, "rdrop_recover");

    // LOS in LINK_UP for 50 clocks.
    los = 1'b1;
    step();
    step();
    chk("los_2clk_state", int'(state), 4);
    step();
    chk("los_3clk_state", int'(state), 5);
    chk("los_pll", int'(pll_reset), 1);
    chk("los_gbt_tx", int'(gbt_tx_reset), 1);
    chk("los_gbt_rx", int'(gbt_rx_reset), 1);
    chk("los_link_up", int'(link_up), 0);
    repeat (47) step();
    chk("los_hold_state", int'(state), 5);
    los = 1'b0;
    step();
    step();
    t0 = m_ticks;
    wait_state(0, 100, "los_to_reset_pll");
    chk_rng("los_holdoff_ticks", m_ticks - t0, 3, 4);
    chk("los_retry", int'(retry_count), 1);
    wait_state(4, 200, "los_relink");

    // Lock loss and LOS in the same cycle.
    lock = 1'b0;
    los  = 1'b1;
    repeat (3) step();
    chk("lockloss_los_state", int'(state), 5);
    chk("lockloss_los_retry", int'(retry_count), 1);
    los = 1'b0;

    // Lock timeout loop up to saturation.
    wait_state(1, 200, "lto_wait_lock");
    t0 = m_ticks;
    wait_state(0, 100, "lto_exit");
    chk_rng("lto_ticks", m_ticks - t0, 5, 6);
    chk("lto_first_retry", int'(retry_count), 2);
    exp_rc = 2;
    for (int i = 0; i < 300 && int'(retry_count) != 255; i++) begin
      wait_state(1, 100, "lto_loop_wait_lock");
      wait_state(0, 100, "lto_loop_exit");
      exp_rc = (exp_rc < 255) ? exp_rc + 1 : 255;
      chk("lto_retry_step", int'(retry_count), exp_rc);
    end
    chk("lto_saturated", int'(retry_count), 255);
    for (int i = 0; i < 2; i++) begin
      wait_state(1, 100, "lto_sat_wait_lock");
      wait_state(0, 100, "lto_sat_exit");
      chk("lto_sat_hold", int'(retry_count), 255);
    end

    // clear_stats coinciding with a lock timeout.
    wait_state(1, 100, "clr_wait_lock");
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (bumps_next()) begin
        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
        found = 1'b1;
      end else begin
        step();
      end
    end
    chk("clr_found_timeout", int'(found), 1);
    chk("clr_state", int'(state), 0);
    chk("clr_retry", int'(retry_count), 0);

    // Ready timeout, then asynchronous reset inside WAIT_READY.
    lock   = 1'b1;
    tx_rdy = 1'b0;
    rx_rdy = 1'b0;
    wait_state(3, 200, "rto_wait_ready");
    wait_state(0, 200, "rto_exit");
    chk("rto_retry", int'(retry_count), 1);
    wait_state(3, 200, "arst_wait_ready");
    repeat (2) step();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_state", int'(state), 0);
    chk("arst_pll", int'(pll_reset), 1);
    chk("arst_gbt_tx", int'(gbt_tx_reset), 1);
    chk("arst_gbt_rx", int'(gbt_rx_reset), 1);
    chk("arst_link_up", int'(link_up), 0);
    chk("arst_retry", int'(retry_count), 0);
    step();
    tx_rdy = 1'b1;
    rx_rdy = 1'b1;
    rst    = 1'b0;
    wait_state(4, 200, "final_link_up");
    chk("final_link_up_o", int'(link_up), 1);
    chk("final_retry", int'(retry_count), 0);
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
